// File: rtl/kvs_regex_pkg.sv
// Shared definitions for the regex matcher feed path: FSM encoding,
// config-word layout and the engine count shared with the matcher.
package kvs_regex_pkg;

    // Number of matcher engines; also the default in-flight value limit.
    localparam int REGEX_ENGINES = 16;

    // Bus widths: value/config words are 512 bits and a pattern fills
    // everything below the broadcast flag.
    localparam int VAL_W         = 512;
    localparam int CFG_BCAST_BIT = 511;
    localparam int PAT_W         = CFG_BCAST_BIT;

    // Feed controller FSM states.
    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_DRAIN  = 2'd2,
        FEED_BCAST  = 2'd3
    } feed_state_e;

    // Build a broadcast config word from a pattern.
    function automatic logic [VAL_W-1:0] bcast_word(input logic [PAT_W-1:0] pat);
        logic [VAL_W-1:0] word;
        word                = {1'b0, pat};
        word[CFG_BCAST_BIT] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/kvs_regex_feed_ctrl_if.sv
// Bus bundle between the KVS value pipeline / pattern source / decision
// consumer on one side and the regex feed controller on the other.
interface kvs_regex_feed_ctrl_if;
    import kvs_regex_pkg::*;

    // Value stream from the KVS read pipeline.
    logic [VAL_W-1:0] val_data;
    logic             val_valid;
    logic             val_last;
    logic             val_ready;

    // Pattern load request.
    logic [PAT_W-1:0] pat_data;
    logic             pat_load;
    logic             pat_busy;

    // Matcher value input.
    logic [VAL_W-1:0] rx_data;
    logic             rx_valid;
    logic             rx_last;
    logic             rx_ready;

    // Matcher config input.
    logic [VAL_W-1:0] cfg_data;
    logic             cfg_valid;
    logic             cfg_ready;

    // Matcher result output.
    logic             fnd_match;
    logic             fnd_valid;
    logic             fnd_ready;

    // Ordered decision stream.
    logic             dec_match;
    logic             dec_valid;
    logic             dec_ready;

    // Controller view.
    modport master (
        input  val_data, val_valid, val_last,
        output val_ready,
        input  pat_data, pat_load,
        output pat_busy,
        output rx_data, rx_valid, rx_last,
        input  rx_ready,
        output cfg_data, cfg_valid,
        input  cfg_ready,
        input  fnd_match, fnd_valid,
        output fnd_ready,
        output dec_match, dec_valid,
        input  dec_ready
    );

    // Environment view (pipeline, matcher and decision consumer).
    modport slave (
        output val_data, val_valid, val_last,
        input  val_ready,
        output pat_data, pat_load,
        input  pat_busy,
        input  rx_data, rx_valid, rx_last,
        output rx_ready,
        input  cfg_data, cfg_valid,
        output cfg_ready,
        output fnd_match, fnd_valid,
        input  fnd_ready,
        input  dec_match, dec_valid,
        output dec_ready
    );

endinterface

// File: rtl/kvs_regex_dec_reg.sv
// One-entry valid/ready register holding the most recent matcher result.
// It accepts a new result in the same cycle the held one is consumed, so
// the decision stream runs at one result per cycle while dec_ready is high.
module kvs_regex_dec_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic fnd_match,
    input  logic fnd_valid,
    output logic fnd_ready,
    output logic dec_match,
    output logic dec_valid,
    input  logic dec_ready
);

    logic dec_match_r;
    logic dec_valid_r;
    logic fnd_hs_s;

    assign fnd_ready = !dec_valid_r || dec_ready;
    assign fnd_hs_s  = fnd_valid && fnd_ready;
    assign dec_match = dec_match_r;
    assign dec_valid = dec_valid_r;

    // Capture a result on the fnd handshake, release it on the dec handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_valid_r <= 1'b0;
            dec_match_r <= 1'b0;
        end else if (fnd_hs_s) begin
            dec_valid_r <= 1'b1;
            dec_match_r <= fnd_match;
        end else if (dec_ready) begin
            dec_valid_r <= 1'b0;
        end else begin
            dec_valid_r <= dec_valid_r;
        end
    end

endmodule

// File: rtl/kvs_regex_feed_ctrl.sv
// Initiator-side controller for the 16-engine regex matcher. Streams value
// words through with zero latency, limits outstanding values to the engine
// count, republishes in-order match results, and drains the matcher before
// broadcasting a newly loaded pattern.
module kvs_regex_feed_ctrl
    import kvs_regex_pkg::*;
#(
    parameter int MAX_INFLIGHT = REGEX_ENGINES,
    parameter int CNT_BITS     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    kvs_regex_feed_ctrl_if.master  bus,
    output logic [CNT_BITS-1:0]    stat_values,
    output logic [CNT_BITS-1:0]    stat_matches
);

    localparam int                  INF_W    = $clog2(MAX_INFLIGHT + 1);
    localparam logic [INF_W-1:0]    INF_MAX  = INF_W'(MAX_INFLIGHT);
    localparam logic [INF_W-1:0]    INF_ZERO = {INF_W{1'b0}};
    localparam logic [INF_W-1:0]    INF_ONE  = INF_W'(1);
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    localparam logic [1:0] S_IDLE   = FEED_IDLE;
    localparam logic [1:0] S_STREAM = FEED_STREAM;
    localparam logic [1:0] S_DRAIN  = FEED_DRAIN;
    localparam logic [1:0] S_BCAST  = FEED_BCAST;

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [INF_W-1:0]    inflight_r;
    logic [INF_W-1:0]    inflight_nxt_s;
    logic                pend_r;
    logic                pend_nxt_s;
    logic [PAT_W-1:0]    pat_r;
    logic [PAT_W-1:0]    pat_nxt_s;
    logic [PAT_W-1:0]    stage_r;
    logic [PAT_W-1:0]    stage_nxt_s;
    logic                stage_vld_r;
    logic                stage_vld_nxt_s;
    logic                cfg_valid_r;
    logic                pat_busy_r;
    logic [CNT_BITS-1:0] stat_values_r;
    logic [CNT_BITS-1:0] stat_matches_r;

    logic in_stream_s;
    logic rx_last_hs_s;
    logic fnd_hs_s;
    logic cfg_hs_s;
    logic dec_hs_s;
    logic fnd_ready_s;
    logic dec_match_s;
    logic dec_valid_s;

    // Value path: a straight pass-through that only opens in STREAM.
    assign in_stream_s   = (state_r == S_STREAM);
    assign bus.val_ready = in_stream_s && bus.rx_ready;
    assign bus.rx_valid  = in_stream_s && bus.val_valid;
    assign bus.rx_data   = bus.val_data;
    assign bus.rx_last   = bus.val_last;

    assign rx_last_hs_s  = in_stream_s && bus.val_valid && bus.rx_ready && bus.val_last;
    assign fnd_hs_s      = bus.fnd_valid && fnd_ready_s;
    assign cfg_hs_s      = cfg_valid_r && bus.cfg_ready;
    assign dec_hs_s      = dec_valid_s && bus.dec_ready;

    // cfg_valid_r is high exactly while the FSM sits in BCAST, and pat_r is
    // frozen there (late loads go to the stage register), so the word is stable.
    assign bus.cfg_data  = bcast_word(pat_r);
    assign bus.cfg_valid = cfg_valid_r;
    assign bus.pat_busy  = pat_busy_r;
    assign bus.fnd_ready = fnd_ready_s;
    assign bus.dec_match = dec_match_s;
    assign bus.dec_valid = dec_valid_s;

    assign stat_values   = stat_values_r;
    assign stat_matches  = stat_matches_r;

    kvs_regex_dec_reg u_dec_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .fnd_match (bus.fnd_match),
        .fnd_valid (bus.fnd_valid),
        .fnd_ready (fnd_ready_s),
        .dec_match (dec_match_s),
        .dec_valid (dec_valid_s),
        .dec_ready (bus.dec_ready)
    );

    // Next-state logic; a pending pattern takes priority over starting a value.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pend_r) begin
                    state_nxt_s = S_DRAIN;
                end else if (stage_vld_r) begin
                    state_nxt_s = S_IDLE;
                end else if (bus.val_valid && (inflight_r < INF_MAX)) begin
                    state_nxt_s = S_STREAM;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_STREAM: begin
                if (rx_last_hs_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_STREAM;
                end
            end
            S_DRAIN: begin
                if (inflight_r == INF_ZERO) begin
                    state_nxt_s = S_BCAST;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_BCAST: begin
                if (cfg_hs_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_BCAST;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Outstanding-value counter; a result with nothing outstanding is ignored.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({rx_last_hs_s, fnd_hs_s})
            2'b10: begin
                if (inflight_r != INF_MAX) begin
                    inflight_nxt_s = inflight_r + INF_ONE;
                end else begin
                    inflight_nxt_s = inflight_r;
                end
            end
            2'b01: begin
                if (inflight_r != INF_ZERO) begin
                    inflight_nxt_s = inflight_r - INF_ONE;
                end else begin
                    inflight_nxt_s = inflight_r;
                end
            end
            default: begin
                inflight_nxt_s = inflight_r;
            end
        endcase
    end

    // Pattern capture; a load during a broadcast is parked and applied after it.
    always_comb begin
        pat_nxt_s       = pat_r;
        stage_nxt_s     = stage_r;
        stage_vld_nxt_s = stage_vld_r;
        if (cfg_hs_s) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end
        if (bus.pat_load) begin
            if (state_r == S_BCAST) begin
                stage_nxt_s     = bus.pat_data;
                stage_vld_nxt_s = 1'b1;
            end else begin
                pat_nxt_s       = bus.pat_data;
                pend_nxt_s      = 1'b1;
                stage_vld_nxt_s = 1'b0;
            end
        end else if (stage_vld_r && (state_r != S_BCAST)) begin
            pat_nxt_s       = stage_r;
            pend_nxt_s      = 1'b1;
            stage_vld_nxt_s = 1'b0;
        end else begin
            stage_vld_nxt_s = stage_vld_r;
        end
    end

    // Control state, pattern registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            inflight_r  <= INF_ZERO;
            pend_r      <= 1'b0;
            pat_r       <= {PAT_W{1'b0}};
            stage_r     <= {PAT_W{1'b0}};
            stage_vld_r <= 1'b0;
            cfg_valid_r <= 1'b0;
            pat_busy_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            inflight_r  <= inflight_nxt_s;
            pend_r      <= pend_nxt_s;
            pat_r       <= pat_nxt_s;
            stage_r     <= stage_nxt_s;
            stage_vld_r <= stage_vld_nxt_s;
            cfg_valid_r <= (state_nxt_s == S_BCAST);
            pat_busy_r  <= pend_nxt_s || stage_vld_nxt_s || (state_nxt_s == S_BCAST);
        end
    end

    // Statistics: count emitted decisions and matching decisions, wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_values_r  <= CNT_ZERO;
            stat_matches_r <= CNT_ZERO;
        end else if (dec_hs_s) begin
            stat_values_r <= stat_values_r + CNT_ONE;
            if (dec_match_s) begin
                stat_matches_r <= stat_matches_r + CNT_ONE;
            end else begin
                stat_matches_r <= stat_matches_r;
            end
        end else begin
            stat_values_r  <= stat_values_r;
            stat_matches_r <= stat_matches_r;
        end
    end

endmodule

// File: tb/tb_kvs_regex_feed_ctrl.sv
// Scoreboard bench for kvs_regex_feed_ctrl: the bench plays pipeline,
// matcher and decision consumer; expected rx beats, config words and
// decisions are queued when driven and compared when the DUT emits them.
module tb_kvs_regex_feed_ctrl;

    logic clk;
    logic rst_n;
    logic [31:0] stat_values;
    logic [31:0] stat_matches;

    kvs_regex_feed_ctrl_if bus_if ();

    kvs_regex_feed_ctrl #(
        .MAX_INFLIGHT (16),
        .CNT_BITS     (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if.master),
        .stat_values  (stat_values),
        .stat_matches (stat_matches)
    );

    int n_tests;
    int n_fail;
    int sent_total;
    int match_total;

    logic [512:0] rx_q[$];
    logic [511:0] cfg_q[$];
    logic         dec_q[$];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Matcher value port monitor.
    always @(negedge clk) begin
        logic [512:0] e;
        if (rst_n && bus_if.rx_valid && bus_if.rx_ready) begin
            chk_eq("rx_expected", 512'(rx_q.size() != 0), 512'(1'b1));
            if (rx_q.size() != 0) begin
                e = rx_q.pop_front();
                chk_eq("rx_data", bus_if.rx_data, e[511:0]);
                chk_eq("rx_last", 512'(bus_if.rx_last), 512'(e[512]));
            end
        end
    end

    // Matcher config port monitor.
    always @(negedge clk) begin
        logic [511:0] e;
        if (rst_n && bus_if.cfg_valid && bus_if.cfg_ready) begin
            chk_eq("cfg_expected", 512'(cfg_q.size() != 0), 512'(1'b1));
            if (cfg_q.size() != 0) begin
                e = cfg_q.pop_front();
                chk_eq("cfg_data", bus_if.cfg_data, e);
            end
        end
    end

    // Decision stream monitor.
    always @(negedge clk) begin
        logic e;
        if (rst_n && bus_if.dec_valid && bus_if.dec_ready) begin
            chk_eq("dec_expected", 512'(dec_q.size() != 0), 512'(1'b1));
            if (dec_q.size() != 0) begin
                e = dec_q.pop_front();
                chk_eq("dec_match", 512'(bus_if.dec_match), 512'(e));
            end
        end
    end

    // Wait (bounded) for val_ready at a falling edge.
    task automatic wait_val_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_if.val_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 512'(bus_if.val_ready), 512'(1'b1));
    endtask

    // Drive a value of the given length; entered and left at posedge+1.
    task automatic send_value(input int words);
        logic [511:0] d;
        for (int w = 0; w < words; w++) begin
            for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
            bus_if.val_data  = d;
            bus_if.val_last  = (w == words - 1);
            bus_if.val_valid = 1'b1;
            rx_q.push_back({bus_if.val_last, d});
            wait_val_ready("val_accept");
            @(posedge clk);
            #1;
        end
        bus_if.val_valid = 1'b0;
        bus_if.val_last  = 1'b0;
    endtask

    // Return one matcher result; entered and left at posedge+1.
    task automatic send_fnd(input logic m);
        int n;
        bus_if.fnd_valid = 1'b1;
        bus_if.fnd_match = m;
        n = 0;
        @(negedge clk);
        while (!bus_if.fnd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_eq("fnd_accept", 512'(bus_if.fnd_ready), 512'(1'b1));
        dec_q.push_back(m);
        sent_total++;
        if (m) match_total++;
        @(posedge clk);
        #1;
        bus_if.fnd_valid = 1'b0;
        @(negedge clk);
        chk_eq("dec_valid_lat", 512'(bus_if.dec_valid), 512'(1'b1));
        chk_eq("dec_match_lat", 512'(bus_if.dec_match), 512'(m));
        @(posedge clk);
        #1;
    endtask

    // Wait for all decisions to be emitted, then compare the statistics.
    task automatic drain_and_check_stats();
        int n;
        n = 0;
        while (dec_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_eq("dec_drain", 512'(dec_q.size()), 512'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_eq("stat_values", 512'(stat_values), 512'(sent_total));
        chk_eq("stat_matches", 512'(stat_matches), 512'(match_total));
        @(posedge clk);
        #1;
    endtask

    // Safety net against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        logic [511:0] cfg_exp;
        logic [511:0] d;
        n_tests = 0; n_fail = 0; sent_total = 0; match_total = 0;
        rst_n = 1'b0;
        bus_if.val_data = 512'd0; bus_if.val_valid = 1'b0; bus_if.val_last = 1'b0;
        bus_if.pat_data = 511'd0; bus_if.pat_load = 1'b0;
        bus_if.rx_ready = 1'b1; bus_if.cfg_ready = 1'b1;
        bus_if.fnd_match = 1'b0; bus_if.fnd_valid = 1'b0;
        bus_if.dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        chk_eq("rst_val_ready", 512'(bus_if.val_ready), 512'(1'b0));
        chk_eq("rst_rx_valid", 512'(bus_if.rx_valid), 512'(1'b0));
        chk_eq("rst_cfg_valid", 512'(bus_if.cfg_valid), 512'(1'b0));
        chk_eq("rst_pat_busy", 512'(bus_if.pat_busy), 512'(1'b0));
        chk_eq("rst_fnd_ready", 512'(bus_if.fnd_ready), 512'(1'b1));
        chk_eq("rst_dec_valid", 512'(bus_if.dec_valid), 512'(1'b0));
        chk_eq("rst_stat_values", 512'(stat_values), 512'(0));
        @(posedge clk);
        #1;

        // One 3-word value, matcher answers 1.
        send_value(3);
        send_fnd(1'b1);
        drain_and_check_stats();

        // 17 single-word values with no results: the 17th must stall.
        for (int i = 0; i < 16; i++) send_value(1);
        chk_eq("inflight_full", 512'(dut.inflight_r), 512'(16));
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
        bus_if.val_data = d; bus_if.val_last = 1'b1; bus_if.val_valid = 1'b1;
        rx_q.push_back({1'b1, d});
        repeat (6) begin
            @(negedge clk);
            chk_eq("v17_stall", 512'(bus_if.val_ready), 512'(1'b0));
        end
        @(posedge clk);
        #1;
        send_fnd(1'b0);
        @(negedge clk);
        chk_eq("v17_start", 512'(bus_if.val_ready), 512'(1'b1));
        @(posedge clk);
        #1;
        bus_if.val_valid = 1'b0; bus_if.val_last = 1'b0;
        for (int i = 0; i < 16; i++) send_fnd((i % 3) == 0);
        drain_and_check_stats();

        // Pattern load with 4 values in flight.
        for (int i = 0; i < 4; i++) send_value(1);
        bus_if.cfg_ready = 1'b0;
        bus_if.pat_data  = 511'h5A;
        bus_if.pat_load  = 1'b1;
        cfg_exp = 512'h5A;
        cfg_exp[511] = 1'b1;
        cfg_q.push_back(cfg_exp);
        @(posedge clk);
        #1;
        bus_if.pat_load = 1'b0;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
        bus_if.val_data = d; bus_if.val_last = 1'b1; bus_if.val_valid = 1'b1;
        rx_q.push_back({1'b1, d});
        @(negedge clk);
        chk_eq("pat_busy_set", 512'(bus_if.pat_busy), 512'(1'b1));
        repeat (5) begin
            @(negedge clk);
            chk_eq("drain_hold", 512'(bus_if.val_ready), 512'(1'b0));
            chk_eq("drain_no_cfg", 512'(bus_if.cfg_valid), 512'(1'b0));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_fnd(i[0]);
        @(negedge clk);
        chk_eq("cfg_present", 512'(bus_if.cfg_valid), 512'(1'b1));
        chk_eq("cfg_word", bus_if.cfg_data, cfg_exp);
        chk_eq("pat_busy_bcast", 512'(bus_if.pat_busy), 512'(1'b1));
        @(posedge clk);
        #1;
        bus_if.cfg_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_eq("pat_busy_clear", 512'(bus_if.pat_busy), 512'(1'b0));
        chk_eq("cfg_done", 512'(cfg_q.size()), 512'(0));
        wait_val_ready("post_bcast_val");
        @(posedge clk);
        #1;
        bus_if.val_valid = 1'b0; bus_if.val_last = 1'b0;
        send_fnd(1'b1);
        drain_and_check_stats();

        // Simultaneous rx last and fnd handshakes at inflight 5.
        for (int i = 0; i < 5; i++) send_value(1);
        chk_eq("inflight_pre", 512'(dut.inflight_r), 512'(5));
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
        bus_if.val_data = d; bus_if.val_last = 1'b1; bus_if.val_valid = 1'b1;
        rx_q.push_back({1'b1, d});
        wait_val_ready("sim_val");
        bus_if.fnd_valid = 1'b1;
        bus_if.fnd_match = 1'b1;
        chk_eq("sim_fnd_ready", 512'(bus_if.fnd_ready), 512'(1'b1));
        dec_q.push_back(1'b1);
        sent_total++; match_total++;
        @(posedge clk);
        #1;
        bus_if.val_valid = 1'b0; bus_if.val_last = 1'b0; bus_if.fnd_valid = 1'b0;
        chk_eq("inflight_same", 512'(dut.inflight_r), 512'(5));
        for (int i = 0; i < 5; i++) send_fnd(1'b0);
        drain_and_check_stats();

        // Decision backpressure: order 1,0,1 with dec_ready low 10 cycles.
        for (int i = 0; i < 3; i++) send_value(1);
        bus_if.dec_ready = 1'b0;
        send_fnd(1'b1);
        fork
            begin
                send_fnd(1'b0);
                send_fnd(1'b1);
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk_eq("fnd_backpressure", 512'(bus_if.fnd_ready), 512'(1'b0));
                end
                @(posedge clk);
                #1;
                bus_if.dec_ready = 1'b1;
            end
        join
        drain_and_check_stats();

        // Reset in the middle of a value, then a clean value.
        send_value(1);
        send_value(1);
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
        bus_if.val_data = d; bus_if.val_last = 1'b0; bus_if.val_valid = 1'b1;
        rx_q.push_back({1'b0, d});
        wait_val_ready("mid_val");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus_if.val_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sent_total = 0;
        match_total = 0;
        @(negedge clk);
        chk_eq("rr_state", 512'(dut.state_r), 512'(0));
        chk_eq("rr_inflight", 512'(dut.inflight_r), 512'(0));
        chk_eq("rr_stat_values", 512'(stat_values), 512'(0));
        chk_eq("rr_stat_matches", 512'(stat_matches), 512'(0));
        chk_eq("rr_val_ready", 512'(bus_if.val_ready), 512'(1'b0));
        @(posedge clk);
        #1;
        send_value(2);
        chk_eq("rr_inflight_one", 512'(dut.inflight_r), 512'(1));
        send_fnd(1'b1);
        drain_and_check_stats();
        chk_eq("rx_all_seen", 512'(rx_q.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kvs_regex_feed_ctrl.md
# kvs_regex_feed_ctrl

Initiator-side controller for the 16-engine regex matcher block. It feeds that block with value words and configuration words, and keeps the number of outstanding values within the engines' capacity. It collects the per-value match bits, which return in dispatch order, and republishes them as an ordered decision stream. When a new pattern is loaded, it drains in-flight work and then issues a broadcast configuration word. It sits between the KVS value-read pipeline and the matcher.

## Interface
Parameters:
- MAX_INFLIGHT, 16, maximum values dispatched but not yet decided; must equal the matcher engine count.
- CNT_BITS, 32, width of the statistics counters.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- val_data  in  512  value word from the KVS pipeline.
- val_valid  in  1  value word valid.
- val_last  in  1  last word of the value.
- val_ready  out  1  value word accepted when val_valid && val_ready.
- pat_data  in  511  new regex pattern (bits 510:0).
- pat_load  in  1  one-cycle pulse; latches pat_data.
- pat_busy  out  1  a pattern is pending or being broadcast.
- rx_data  out  512  matcher value input.
- rx_valid  out  1  matcher value input valid.
- rx_last  out  1  matcher value input last.
- rx_ready  in  1  matcher value input ready.
- cfg_data  out  512  matcher config word; bit 511 = 1 means broadcast.
- cfg_valid  out  1  matcher config valid.
- cfg_ready  in  1  matcher config ready.
- fnd_match  in  1  matcher result bit.
- fnd_valid  in  1  matcher result valid.
- fnd_ready  out  1  matcher result ready.
- dec_match  out  1  ordered decision, 1 = value matched.
- dec_valid  out  1  decision valid.
- dec_ready  in  1  decision consumer ready.
- stat_values  out  CNT_BITS  values whose decision has been emitted.
- stat_matches  out  CNT_BITS  emitted decisions with dec_match = 1.

## Operation
- FSM states: IDLE, STREAM, DRAIN, BCAST.
  - IDLE: no value is open. Moves to STREAM when val_valid && inflight < MAX_INFLIGHT && !pend. Moves to DRAIN when pend is set.
  - STREAM: value words pass through to the rx_* port. val_ready = rx_ready and rx_valid = val_valid, combinational, with zero latency. A beat accepted with last returns the FSM to IDLE and increments inflight.
  - DRAIN: waits for inflight == 0, then moves to BCAST.
  - BCAST: cfg_data = {1'b1, pat_reg} and cfg_valid = 1 until cfg_ready. On the handshake, clear pend and return to IDLE.
- In IDLE, DRAIN and BCAST, val_ready = 0 and rx_valid = 0.
- Value start is gated only at the first word. A value already in STREAM always completes, even if inflight has reached MAX_INFLIGHT.
- pat_load latches pat_data into pat_reg and sets pend.
  - A pat_load during BCAST is applied after the current broadcast: pend is set again and pat_reg is updated on the following cycle.
  - A pat_load during STREAM takes effect at the next IDLE.
- pat_busy = pend || (state == BCAST).
- inflight is a counter from 0 to MAX_INFLIGHT.
  - +1 on an rx last handshake; -1 on an fnd handshake.
  - When both happen in the same cycle, inflight is unchanged.
  - An fnd handshake when inflight = 0 is a protocol error: the counter holds at 0 and the beat is still forwarded.
- The decision output is a one-entry register.
  - fnd_ready = !dec_valid || dec_ready.
  - On an fnd handshake, dec_match <= fnd_match and dec_valid <= 1.
- Statistics counters increment on each dec handshake and wrap at 2^CNT_BITS.

## Timing
- Reset values: FSM = IDLE; inflight = 0; pend = 0; pat_reg = 0; dec_valid = 0; dec_match = 0; both statistics counters = 0. As a result, val_ready, rx_valid, cfg_valid and pat_busy are all 0, and fnd_ready = 1 after reset.
- Reset asserted mid-value or mid-broadcast drops all state at the next edge. Any partial output is abandoned and the matcher must be reset alongside this block.
- Value path latency is 0 cycles.
- Decision latency: fnd handshake to dec_valid is 1 cycle. Full throughput is sustained: the output register accepts a new result every cycle while dec_ready = 1.
- The first value word can be accepted on the cycle after the FSM enters IDLE.
- The broadcast config word is presented on the cycle after inflight reaches 0 in DRAIN.
- All outputs are registered except val_ready, rx_* and fnd_ready.

## Structure
- Shared kvs_regex_pkg holds:
  - the FSM state enum;
  - CFG_BCAST_BIT = 511;
  - a default of 16 for MAX_INFLIGHT, which is shared with the matcher.
- One sub-module, kvs_regex_dec_reg: the one-entry valid/ready result register with its fnd_ready logic.

## Test plan
- One 3-word value and the matcher returning 1 -> three rx beats, with rx_last on beat 3. dec_match = 1 one cycle after fnd. Final counts: stat_values = 1, stat_matches = 1.
- 17 single-word values with fnd held invalid:
  - 16 values are accepted; val_ready stays 0 on value 17.
  - One fnd beat then lets value 17 start on the next IDLE cycle.
- pat_load = 0x5A while 4 values are in flight:
  - Hold the value stream in DRAIN.
  - After 4 fnd beats, a cfg word is presented with bit 511 = 1 and bits 510:0 = 0x5A.
  - pat_busy falls on the cfg handshake.
- An rx last handshake and an fnd handshake in the same cycle with inflight = 5 -> inflight stays 5.
- dec_ready held 0 for 10 cycles while fnd_valid = 1:
  - After the first capture, fnd_ready = 0 and no result is lost.
  - Match order is preserved in the sequence 1,0,1.
- rst_n asserted mid-STREAM, then a new value sent -> FSM returns to IDLE, inflight = 0 and both counters = 0, and the new value is processed normally.
